prio_event_encoder: RTL and testbench

//   Parametrised, registered successor to the team's 8:3 priority encoder.
//   - Captures single-cycle event pulses on N request lines into a pending register.
//   - Masks the pending bits, then presents the highest-priority index on a valid/ready output.
//   - Clears each pending bit when its index is accepted.
//   - Sits between interrupt/event sources and a single consumer (controller or CPU IRQ port).

---
 rtl/prio_enc_pkg.sv | 17 +
 rtl/prio_enc_comb.sv | 28 ++
 rtl/prio_event_encoder.sv | 98 +++++++++
 tb/tb_prio_event_encoder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/prio_enc_pkg.sv
// Shared types and helpers for the registered priority event encoder.
package prio_enc_pkg;

  typedef enum logic {IDLE, HOLD} state_t;

  localparam int PRIO_N_MAX = 64;

  // One-hot vector of idx, all-zero when idx lies outside 0..n-1.
  function automatic logic [PRIO_N_MAX-1:0] onehot(input int idx, input int n);
    logic [PRIO_N_MAX-1:0] v;
    v = '0;
    if (idx >= 0 && idx < n)
      v = {{(PRIO_N_MAX-1){1'b0}}, 1'b1} << idx;
    return v;
  endfunction

endpackage

// File: rtl/prio_enc_comb.sv
// Combinational circular search: first set bit of vec scanning downward from start,
// wrapping from 0 to N-1.
module prio_enc_comb #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         found
);

  logic [W-1:0] pos;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = start;
    for (int k = 0; k < N; k++) begin
      if (!found && vec[pos]) begin
        idx   = pos;
        found = 1'b1;
      end
      pos = (pos == '0) ? W'(N-1) : pos - W'(1);
    end
  end

endmodule

// File: rtl/prio_event_encoder.sv
// Pending-event register with masked priority selection on a valid/ready output.
// Optional build macro: ROUND_ROBIN_EN (rotating priority, last served line lowest).
module prio_event_encoder
  import prio_enc_pkg::*;
#(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  logic         out_ready,
  input  logic         ovf_clr,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] pending,
  output logic         ovf
);

  state_t       state;
  logic         hs;
  logic [N-1:0] pop_vec;
  logic [N-1:0] cand;
  logic [W-1:0] start;
  logic [W-1:0] sel_idx;
  logic         sel_found;

  assign hs      = out_valid & out_ready;
  assign pop_vec = hs ? N'(onehot(int'(out_idx), N)) : '0;
  // The line being popped this edge must not be re-offered from the stale pending bit.
  assign cand    = pending & mask & ~pop_vec;

`ifdef ROUND_ROBIN_EN
  logic [W-1:0] rr_ptr;

  assign start = (rr_ptr == '0) ? W'(N-1) : rr_ptr - W'(1);

  always_ff @(posedge clk) begin
    if (rst)
      rr_ptr <= W'(N-1);
    else if (hs)
      rr_ptr <= out_idx;
  end
`else
  assign start = W'(N-1);
`endif

  prio_enc_comb #(.N(N)) u_sel (
    .vec   (cand),
    .start (start),
    .idx   (sel_idx),
    .found (sel_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_idx   <= '0;
      pending   <= '0;
      ovf       <= 1'b0;
    end else begin
      // A req on the popped bit keeps that bit pending.
      pending <= (pending & ~pop_vec) | req;

      if (|(req & pending & ~pop_vec))
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;

      case (state)
        IDLE: begin
          if (sel_found) begin
            out_idx   <= sel_idx;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (sel_found) begin
              out_idx <= sel_idx;
            end else begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prio_event_encoder.sv
// Directed bench for prio_event_encoder (N=8); expectations follow ROUND_ROBIN_EN when defined.
module tb_prio_event_encoder;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] mask;
  logic       out_ready;
  logic       ovf_clr;
  logic       out_valid;
  logic [2:0] out_idx;
  logic [7:0] pending;
  logic       ovf;

  int n_cmp = 0;
  int n_err = 0;

  prio_event_encoder #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mask      (mask),
    .out_ready (out_ready),
    .ovf_clr   (ovf_clr),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .pending   (pending),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int exp6[6];
  logic [2:0] first2, second2;
  logic [7:0] pend2;

  initial begin
`ifdef ROUND_ROBIN_EN
    exp6   = '{1, 3, 2, 1, 3, 2};
    first2 = 3'd0; second2 = 3'd7; pend2 = 8'h80;
`else
    exp6   = '{3, 2, 3, 2, 3, 2};
    first2 = 3'd7; second2 = 3'd0; pend2 = 8'h01;
`endif
    rst = 1'b1; req = '0; mask = 8'hFF; out_ready = 1'b0; ovf_clr = 1'b0;
    step(); step();
    chk("rst_valid", out_valid, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_pending", pending, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;

    // Idle with no requests
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_valid", out_valid, 0);
      chk("idle_pending", pending, 0);
      chk("idle_ovf", ovf, 0);
    end

    // Two simultaneous events, drained back-to-back
    out_ready = 1'b1; req = 8'h81;
    step();
    chk("t2_pending", pending, 8'h81);
    chk("t2_valid0", out_valid, 0);
    req = '0;
    step();
    chk("t2_valid1", out_valid, 1);
    chk("t2_idx_a", out_idx, first2);
    step();
    chk("t2_valid2", out_valid, 1);
    chk("t2_idx_b", out_idx, second2);
    chk("t2_pend_b", pending, pend2);
    step();
    chk("t2_valid3", out_valid, 0);
    chk("t2_pend_end", pending, 0);

    // Masked line held pending, offered once unmasked
    out_ready = 1'b0; mask = 8'hEF; req = 8'h10;
    step();
    chk("t3_pending", pending, 8'h10);
    req = '0;
    step();
    chk("t3_masked_a", out_valid, 0);
    step();
    chk("t3_masked_b", out_valid, 0);
    mask = 8'hFF;
    step();
    chk("t3_valid", out_valid, 1);
    chk("t3_idx", out_idx, 4);
    out_ready = 1'b1;
    step();
    chk("t3_drained", out_valid, 0);
    chk("t3_pend_end", pending, 0);
    out_ready = 1'b0;

    // Held offer, overflow, mask change, ovf_clr priority
    req = 8'h08;
    step();
    req = '0;
    step();
    chk("t4_valid", out_valid, 1);
    chk("t4_idx", out_idx, 3);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t4_hold_idx", out_idx, 3);
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_ovf", ovf, 0);
    end
    req = 8'h08;
    step();
    chk("t4_ovf_set", ovf, 1);
    chk("t4_idx_kept", out_idx, 3);
    req = '0; mask = 8'h00;
    step();
    chk("t4_mask_valid", out_valid, 1);
    chk("t4_mask_idx", out_idx, 3);
    mask = 8'hFF; ovf_clr = 1'b1;
    step();
    chk("t4_ovf_clr", ovf, 0);
    req = 8'h08;
    step();
    chk("t4_set_wins", ovf, 1);
    req = '0;
    step();
    chk("t4_ovf_clr2", ovf, 0);
    ovf_clr = 1'b0; out_ready = 1'b1;
    step();
    chk("t4_drained", out_valid, 0);
    chk("t4_pend_end", pending, 0);
    out_ready = 1'b0;

    // Re-request on the line being accepted keeps it pending
    req = 8'h04;
    step();
    req = '0;
    step();
    chk("t5_idx", out_idx, 2);
    out_ready = 1'b1; req = 8'h04;
    step();
    chk("t5_pending", pending, 8'h04);
    chk("t5_ovf", ovf, 0);
    chk("t5_valid_gap", out_valid, 0);
    req = '0; out_ready = 1'b0;
    step();
    chk("t5_reoffer_v", out_valid, 1);
    chk("t5_reoffer_idx", out_idx, 2);
    out_ready = 1'b1;
    step();
    chk("t5_drained", out_valid, 0);
    out_ready = 1'b0;

    // Three lines, accepted line re-requested on every handshake
    req = 8'h0E;
    step();
    req = '0;
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("t6_valid", out_valid, 1);
      chk("t6_idx", out_idx, exp6[i]);
      req = 8'h01 << exp6[i];
      step();
      chk("t6_pending", pending, 8'h0E);
      chk("t6_ovf", ovf, 0);
    end
    req = '0;

    // Reset mid-operation discards pending work and the offer
    rst = 1'b1;
    step();
    chk("rst2_valid", out_valid, 0);
    chk("rst2_idx", out_idx, 0);
    chk("rst2_pending", pending, 0);
    rst = 1'b0; out_ready = 1'b0;
    step();
    chk("rst2_idle", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
